// File: rtl/ofmap_writer_if.sv
// ofmap_writer_if
//   Bundles the result-word stream (valid/ready) and the output-buffer write
//   port of ofmap_writer.
//   slave  : the writer side (consumes in_*, drives in_ready and wr_*)
//   master : the datapath/buffer side (drives in_*, observes in_ready and wr_*)
// Signals:
//   in_valid, in_data, in_ready  result stream handshake
//   wr_en, wr_i, wr_j, wr_data   registered write port to the output buffer
interface ofmap_writer_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 7
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_i;
  logic [ADDR_W-1:0] wr_j;
  logic [DATA_W-1:0] wr_data;

  modport slave (
    input  in_valid, in_data,
    output in_ready, wr_en, wr_i, wr_j, wr_data
  );

  modport master (
    output in_valid, in_data,
    input  in_ready, wr_en, wr_i, wr_j, wr_data
  );
endinterface

// File: rtl/ofmap_writer.sv
// ofmap_writer
//   Write-side address generator for the output feature map. Accepts result
//   words and writes them to the output buffer, walking a 2x2 arrangement of
//   TILE x TILE tiles (quadrant order matches the input-side read counter).
//   Emits tile_done / frame_done pulses for the top-level sequencer.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   start        one-cycle frame start, honoured only in IDLE
//   bus          ofmap_writer_if.slave: in_valid/in_data/in_ready stream in,
//                wr_en/wr_i/wr_j/wr_data registered write port out
//   tile_done    one-cycle pulse, coincides with the write of a tile's last word
//   frame_done   one-cycle pulse, cycle after the fourth tile_done
//   busy         high in every state except IDLE
// Build option:
//   OFMAP_RELU_EN  when defined, negative words are clamped to zero at the
//                  write register (no extra latency).
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | waiting for start, in_ready low
// WRITE     | accepting words, one per cycle, counters advance per accept
// TILE_END  | one bubble cycle after a tile's last accept, tile_done high
// FRAME_END | one bubble cycle after the fourth tile, frame_done high
module ofmap_writer #(
  parameter int DATA_W = 16,
  parameter int TILE   = 8,
  parameter int ADDR_W = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  ofmap_writer_if.slave bus,
  output logic          tile_done,
  output logic          frame_done,
  output logic          busy
);

  localparam int LW = (TILE > 1) ? $clog2(TILE) : 1;

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WRITE     = 2'd1;
  localparam logic [1:0] S_TILE_END  = 2'd2;
  localparam logic [1:0] S_FRAME_END = 2'd3;

  logic [1:0]        state;
  logic [1:0]        q;
  logic [LW-1:0]     li;
  logic [LW-1:0]     lj;
  logic              accept;
  logic              li_last;
  logic              lj_last;
  logic [ADDR_W-1:0] addr_i;
  logic [ADDR_W-1:0] addr_j;
  logic [DATA_W-1:0] data_next;

  assign bus.in_ready = (state == S_WRITE);
  assign accept       = bus.in_valid & bus.in_ready;
  assign li_last      = (li == LW'(TILE - 1));
  assign lj_last      = (lj == LW'(TILE - 1));

  // q[0] selects the upper half of the fast coordinate, q[1] the slow one.
  assign addr_i = ADDR_W'(li) + (q[0] ? ADDR_W'(TILE) : '0);
  assign addr_j = ADDR_W'(lj) + (q[1] ? ADDR_W'(TILE) : '0);

`ifdef OFMAP_RELU_EN
  assign data_next = bus.in_data[DATA_W-1] ? '0 : bus.in_data;
`else
  assign data_next = bus.in_data;
`endif

  // The bubble states double as the completion pulses: TILE_END is exactly
  // the cycle in which the tile's last word is on the write port.
  assign tile_done  = (state == S_TILE_END);
  assign frame_done = (state == S_FRAME_END);
  assign busy       = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      q     <= '0;
      li    <= '0;
      lj    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_WRITE;
            q     <= '0;
            li    <= '0;
            lj    <= '0;
          end
        end
        S_WRITE: begin
          if (accept) begin
            if (li_last) begin
              li <= '0;
              if (lj_last) begin
                lj    <= '0;
                state <= S_TILE_END;
              end else begin
                lj <= lj + 1'b1;
              end
            end else begin
              li <= li + 1'b1;
            end
          end
        end
        S_TILE_END: begin
          li <= '0;
          lj <= '0;
          if (q == 2'd3) begin
            state <= S_FRAME_END;
          end else begin
            q     <= q + 2'd1;
            state <= S_WRITE;
          end
        end
        S_FRAME_END: begin
          state <= S_IDLE;
          q     <= '0;
        end
        default: begin
          state <= S_IDLE;
          q     <= '0;
        end
      endcase
    end
  end

  // Write port: address/data hold their last value between strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.wr_en   <= 1'b0;
      bus.wr_i    <= '0;
      bus.wr_j    <= '0;
      bus.wr_data <= '0;
    end else begin
      bus.wr_en <= accept;
      if (accept) begin
        bus.wr_i    <= addr_i;
        bus.wr_j    <= addr_j;
        bus.wr_data <= data_next;
      end
    end
  end

endmodule

// File: tb/tb_ofmap_writer.sv
module tb_ofmap_writer;

  typedef struct {
    logic [6:0]  i;
    logic [6:0]  j;
    logic [15:0] d;
    bit          last;
  } exp_t;

`ifdef OFMAP_RELU_EN
  localparam logic [15:0] EXP_NEG = 16'h0000;
`else
  localparam logic [15:0] EXP_NEG = 16'hFFF6;
`endif

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic tile_done;
  logic frame_done;
  logic busy;

  int total = 0;
  int bad   = 0;
  int wr_cnt = 0;
  int tile_cnt = 0;
  int frame_cnt = 0;

  exp_t sb[$];
  logic [6:0]  last_i = '0;
  logic [6:0]  last_j = '0;
  logic [15:0] last_d = '0;

  ofmap_writer_if #(.DATA_W(16), .ADDR_W(7)) bus ();

  ofmap_writer #(.DATA_W(16), .TILE(8), .ADDR_W(7)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .bus        (bus),
    .tile_done  (tile_done),
    .frame_done (frame_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [15:0] relu(input logic [15:0] d);
`ifdef OFMAP_RELU_EN
    return d[15] ? 16'h0000 : d;
`else
    return d;
`endif
  endfunction

  function automatic exp_t make_exp(input logic [15:0] d, input int k);
    exp_t e;
    int t, l;
    t = k / 64;
    l = k % 64;
    e.i = 7'(l % 8 + (((t & 1) != 0) ? 8 : 0));
    e.j = 7'(l / 8 + (((t & 2) != 0) ? 8 : 0));
    e.d = relu(d);
    e.last = (l == 63);
    return e;
  endfunction

  // Monitor: pops the scoreboard on every write strobe.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      last_i = '0;
      last_j = '0;
      last_d = '0;
    end else begin
      if (frame_done) frame_cnt++;
      if (tile_done) tile_cnt++;
      if (bus.wr_en) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_wr: wr_en high with no accepted word at %0t", $time);
        end else begin
          e = sb.pop_front();
          wr_cnt++;
          chk("wr_i", 32'(bus.wr_i), 32'(e.i));
          chk("wr_j", 32'(bus.wr_j), 32'(e.j));
          chk("wr_data", 32'(bus.wr_data), 32'(e.d));
          chk("tile_done_on_last", 32'(tile_done), 32'(e.last));
          last_i = e.i;
          last_j = e.j;
          last_d = e.d;
        end
      end else begin
        chk("hold_i", 32'(bus.wr_i), 32'(last_i));
        chk("hold_j", 32'(bus.wr_j), 32'(last_j));
        chk("hold_data", 32'(bus.wr_data), 32'(last_d));
        chk("tile_done_without_wr", 32'(tile_done), 32'(0));
      end
    end
  end

  // Called at a negedge; returns at the negedge on which the word is written.
  task automatic send_word(input logic [15:0] d, input int k);
    int budget;
    budget = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    while (!bus.in_ready && budget < 16) begin
      @(negedge clk);
      budget++;
    end
    if (!bus.in_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: in_ready stayed 0 for word %0d", k);
      bus.in_valid = 1'b0;
      return;
    end
    sb.push_back(make_exp(d, k));
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic run_frame(input int nwords, input bit rnd, input int start_at,
                           input bit start_fe, input logic [15:0] base, input bit spot);
    int fc0;
    int g;
    wr_cnt = 0;
    tile_cnt = 0;
    fc0 = frame_cnt;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'(1));
    for (int k = 0; k < nwords; k++) begin
      if (rnd) begin
        g = 0;
        while ($urandom_range(0, 1) == 0 && g < 6) begin
          bus.in_valid = 1'b0;
          @(negedge clk);
          g++;
        end
      end
      if (k == start_at) start = 1'b1;
      send_word(base + 16'(k), k);
      start = 1'b0;
      if (spot) begin
        case (k)
          0:   begin chk("spot0_i", 32'(bus.wr_i), 0);  chk("spot0_j", 32'(bus.wr_j), 0);
                     chk("spot0_d", 32'(bus.wr_data), 0); end
          8:   begin chk("spot8_i", 32'(bus.wr_i), 0);  chk("spot8_j", 32'(bus.wr_j), 1); end
          64:  begin chk("spot64_i", 32'(bus.wr_i), 8); chk("spot64_j", 32'(bus.wr_j), 0); end
          128: begin chk("spot128_i", 32'(bus.wr_i), 0); chk("spot128_j", 32'(bus.wr_j), 8); end
          255: begin chk("spot255_i", 32'(bus.wr_i), 15); chk("spot255_j", 32'(bus.wr_j), 15);
                     chk("spot255_d", 32'(bus.wr_data), 255); end
          default: ;
        endcase
      end
      if (k % 64 == 63) begin
        chk("tile_gap_ready", 32'(bus.in_ready), 32'(0));
        chk("tile_gap_done", 32'(tile_done), 32'(1));
        @(negedge clk);
        if (k != 255) begin
          chk("tile_resume_ready", 32'(bus.in_ready), 32'(1));
        end else begin
          chk("frame_end_done", 32'(frame_done), 32'(1));
          chk("frame_end_ready", 32'(bus.in_ready), 32'(0));
          chk("frame_end_busy", 32'(busy), 32'(1));
          if (start_fe) start = 1'b1;
          @(negedge clk);
          start = 1'b0;
          chk("idle_busy", 32'(busy), 32'(0));
          chk("idle_frame_done", 32'(frame_done), 32'(0));
          @(negedge clk);
          chk("idle_busy_stays", 32'(busy), 32'(0));
        end
      end
    end
    if (nwords == 256) begin
      chk("frame_wr_count", 32'(wr_cnt), 32'(256));
      chk("frame_tile_count", 32'(tile_cnt), 32'(4));
      chk("frame_done_count", 32'(frame_cnt - fc0), 32'(1));
    end
  endtask

  task automatic abort_reset();
    int fc0;
    #2 rst = 1'b1;
    #1;
    chk("rst_wr_en", 32'(bus.wr_en), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_in_ready", 32'(bus.in_ready), 32'(0));
    chk("rst_tile_done", 32'(tile_done), 32'(0));
    chk("rst_frame_done", 32'(frame_done), 32'(0));
    chk("rst_wr_i", 32'(bus.wr_i), 32'(0));
    chk("rst_wr_j", 32'(bus.wr_j), 32'(0));
    chk("rst_wr_data", 32'(bus.wr_data), 32'(0));
    sb.delete();
    @(negedge clk);
    #2 rst = 1'b0;
    fc0 = frame_cnt;
    repeat (4) @(negedge clk);
    chk("post_rst_no_frame_done", 32'(frame_cnt), 32'(fc0));
    chk("post_rst_idle", 32'(busy), 32'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'(0));
    chk("reset_in_ready", 32'(bus.in_ready), 32'(0));
    chk("reset_wr_en", 32'(bus.wr_en), 32'(0));
    chk("reset_tile_done", 32'(tile_done), 32'(0));
    chk("reset_frame_done", 32'(frame_done), 32'(0));
    chk("reset_wr_i", 32'(bus.wr_i), 32'(0));
    chk("reset_wr_j", 32'(bus.wr_j), 32'(0));
    chk("reset_wr_data", 32'(bus.wr_data), 32'(0));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // full frame, in_valid held high
    run_frame(256, 1'b0, -1, 1'b0, 16'h0000, 1'b1);
    // full frame, random in_valid gaps, data crossing the sign boundary
    run_frame(256, 1'b1, -1, 1'b0, 16'h7F80, 1'b0);
    // abort after 100 accepts, then a clean frame
    run_frame(100, 1'b1, -1, 1'b0, 16'h2000, 1'b0);
    abort_reset();
    run_frame(256, 1'b0, -1, 1'b0, 16'h4000, 1'b1 && 1'b0);
    // start pulses in WRITE and in FRAME_END are ignored
    run_frame(256, 1'b0, 37, 1'b1, 16'h3000, 1'b0);

    // sign handling of the write data
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_word(16'hFFF6, 0);
    chk("neg_word_data", 32'(bus.wr_data), 32'(EXP_NEG));
    send_word(16'h0005, 1);
    chk("pos_word_data", 32'(bus.wr_data), 32'(16'h0005));
    abort_reset();

    chk("scoreboard_empty", 32'(sb.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
